// File: rtl/pulse_cdc_pkg.sv
// Shared definitions for the pulse CDC scheduler.
//   state_e         : handshake FSM states (IDLE, REQ_HI, REQ_LO)
//   SYNC_STAGES_MIN : shallowest synchroniser depth that is safe to configure
//   MAX_REQ         : largest requester count the arbiter helper supports
//   rr_pick()       : round-robin find-first over the pending vector
package pulse_cdc_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int MAX_REQ         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of pend at or after ptr, wrapping within n requesters.
  // Walking the offsets downwards lets the smallest offset overwrite the
  // result last, so no early exit is needed and the loop bound stays constant.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] pend,
                                       input logic [3:0]         ptr,
                                       input int                 n);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (pend[4'(idx)]) begin
          res.valid = 1'b1;
          res.idx   = 4'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_cdc_rx.sv
// Slow-domain receiver of the pulse crossing channel.
//   clk_slow   in  : slow clock
//   rst_n      in  : async active-low reset
//   req_lvl    in  : handshake request level from the fast domain
//   id_in      in  : requester ID, quasi-static while req_lvl is high
//   ack        out : handshake acknowledge (synchronised request, looped back)
//   slow_pulse out : one clk_slow cycle per request rising edge
//   slow_id    out : ID captured with slow_pulse, held until the next event
module pulse_cdc_rx #(
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_slow,
  input  logic            rst_n,
  input  logic            req_lvl,
  input  logic [ID_W-1:0] id_in,
  output logic            ack,
  output logic            slow_pulse,
  output logic [ID_W-1:0] slow_id
);

  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   slow_pulse_q, slow_pulse_d;
  logic [ID_W-1:0]        slow_id_q, slow_id_d;
  logic                   req_rise;

  assign ack      = req_sync_q[SYNC_STAGES-1];
  assign req_rise = req_sync_q[SYNC_STAGES-1] & ~req_seen_q;

  // NOTE: every variable gets its default at the top of always_comb, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    req_sync_d   = {req_sync_q[SYNC_STAGES-2:0], req_lvl};
    req_seen_d   = req_sync_q[SYNC_STAGES-1];
    slow_pulse_d = req_rise;
    slow_id_d    = slow_id_q;
    // id_in has been stable for at least SYNC_STAGES slow cycles by the time
    // the request edge emerges, so a plain capture of the bus is safe.
    if (req_rise) slow_id_d = id_in;
  end

  // NOTE: synchroniser flops are reset too, so a reset in mid-transfer
  // cannot leave a stale request level that would fire a pulse on release.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q   <= '0;
      req_seen_q   <= 1'b0;
      slow_pulse_q <= 1'b0;
      slow_id_q    <= '0;
    end else begin
      req_sync_q   <= req_sync_d;
      req_seen_q   <= req_seen_d;
      slow_pulse_q <= slow_pulse_d;
      slow_id_q    <= slow_id_d;
    end
  end

  assign slow_pulse = slow_pulse_q;
  assign slow_id    = slow_id_q;

endmodule

// File: rtl/pulse_cdc_scheduler.sv
// Shares one fast->slow pulse crossing among NUM_REQ fast-domain requesters.
// Requests are latched into pending bits, arbitrated round-robin, and sent
// one at a time over a 4-phase req/ack handshake carrying the requester ID.
//   clk_fast   in  : fast clock (requesters, arbiter, FSM)
//   rst_n      in  : async active-low reset for both domains
//   clk_slow   in  : slow clock (receiver)
//   req_pulse  in  : one-cycle event per requester
//   req_drop   out : event coalesced because that requester was already pending
//   busy       out : FSM active or any event pending
//   done_pulse out : acknowledge of the current transfer has risen
//   done_id    out : ID of the completed transfer, valid with done_pulse
//   slow_pulse out : one clk_slow cycle per granted event
//   slow_id    out : ID of that event, held until the next one
module pulse_cdc_scheduler
  import pulse_cdc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_fast,
  input  logic               rst_n,
  input  logic               clk_slow,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic [NUM_REQ-1:0] req_drop,
  output logic               busy,
  output logic               done_pulse,
  output logic [ID_W-1:0]    done_id,
  output logic               slow_pulse,
  output logic [ID_W-1:0]    slow_id
);

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [NUM_REQ-1:0]     req_drop_q, req_drop_d;
  logic                   req_lvl_q, req_lvl_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_reg_q, id_reg_d;
  logic                   done_pulse_q, done_pulse_d;
  logic [ID_W-1:0]        done_id_q, done_id_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic                   ack;
  logic                   ack_sync;
  logic [NUM_REQ-1:0]     clr;
  rr_pick_t               pick;
  logic [ID_W-1:0]        win;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign pick     = rr_pick(MAX_REQ'(pending_q), 4'(rr_ptr_q), NUM_REQ);
  assign win      = ID_W'(pick.idx);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_reg_d     = id_reg_q;
    done_pulse_d = 1'b0;
    done_id_d    = done_id_q;
    clr          = '0;
    ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], ack};

    unique case (state_q)
      IDLE: begin
        // id_reg only moves here, while the request level is low, which is
        // what keeps it quasi-static for the slow-side capture.
        if (pick.valid) begin
          clr[win] = 1'b1;
          id_reg_d = win;
          rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win + 1'b1);
          state_d  = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          done_pulse_d = 1'b1;
          done_id_d    = id_reg_q;
          state_d      = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new event on the grant cycle re-arms the bit: set wins over clear.
    pending_d  = (pending_q & ~clr) | req_pulse;
    req_drop_d = req_pulse & pending_q & ~clr;
    req_lvl_d  = (state_d == REQ_HI);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      req_drop_q   <= '0;
      req_lvl_q    <= 1'b0;
      rr_ptr_q     <= '0;
      id_reg_q     <= '0;
      done_pulse_q <= 1'b0;
      done_id_q    <= '0;
      ack_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_drop_q   <= req_drop_d;
      req_lvl_q    <= req_lvl_d;
      rr_ptr_q     <= rr_ptr_d;
      id_reg_q     <= id_reg_d;
      done_pulse_q <= done_pulse_d;
      done_id_q    <= done_id_d;
      ack_sync_q   <= ack_sync_d;
    end
  end

  pulse_cdc_rx #(
    .ID_W        (ID_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk_slow   (clk_slow),
    .rst_n      (rst_n),
    .req_lvl    (req_lvl_q),
    .id_in      (id_reg_q),
    .ack        (ack),
    .slow_pulse (slow_pulse),
    .slow_id    (slow_id)
  );

  assign req_drop   = req_drop_q;
  assign busy       = (state_q != IDLE) | (|pending_q);
  assign done_pulse = done_pulse_q;
  assign done_id    = done_id_q;

endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// Scoreboard bench for pulse_cdc_scheduler: each scenario pushes the
// requester IDs it expects, in order, and monitors pop them as slow_pulse
// and done_pulse appear.
module tb_pulse_cdc_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int IDLE_BUDGET = 3000;

  typedef logic [ID_W-1:0] id_t;

  logic               clk_fast = 1'b0;
  logic               clk_slow = 1'b0;
  logic               rst_n    = 1'b0;
  logic [NUM_REQ-1:0] req_pulse = '0;
  logic [NUM_REQ-1:0] req_drop;
  logic               busy;
  logic               done_pulse;
  id_t                done_id;
  logic               slow_pulse;
  id_t                slow_id;

  int  checks = 0;
  int  errors = 0;
  id_t exp_slow_q[$];
  id_t exp_done_q[$];
  int  drop_cnt[NUM_REQ] = '{default: 0};
  int  slow_events = 0;

  always #5  clk_fast = ~clk_fast;
  always #50 clk_slow = ~clk_slow;

  pulse_cdc_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .clk_slow   (clk_slow),
    .req_pulse  (req_pulse),
    .req_drop   (req_drop),
    .busy       (busy),
    .done_pulse (done_pulse),
    .done_id    (done_id),
    .slow_pulse (slow_pulse),
    .slow_id    (slow_id)
  );

  // Slow-side scoreboard: every slow_pulse must match the oldest expectation.
  always @(negedge clk_slow) begin : mon_slow
    id_t e;
    if (slow_pulse === 1'b1) begin
      slow_events++;
      checks++;
      if (exp_slow_q.size() == 0) begin
        errors++;
        $display("FAIL slow_unexpected: slow_pulse with slow_id=%0d, required no event", slow_id);
      end else begin
        e = exp_slow_q.pop_front();
        if (slow_id !== e) begin
          errors++;
          $display("FAIL slow_id: got %0d, required %0d", slow_id, e);
        end
      end
    end
  end

  // Fast-side scoreboard for done_pulse, plus per-requester drop counters.
  always @(negedge clk_fast) begin : mon_fast
    id_t e;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_drop[i] === 1'b1) drop_cnt[i]++;
    if (done_pulse === 1'b1) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done_pulse with done_id=%0d, required no event", done_id);
      end else begin
        e = exp_done_q.pop_front();
        if (done_id !== e) begin
          errors++;
          $display("FAIL done_id: got %0d, required %0d", done_id, e);
        end
      end
    end
  end

  task automatic expect_id(input id_t id);
    exp_slow_q.push_back(id);
    exp_done_q.push_back(id);
  endtask

  task automatic pulse(input logic [NUM_REQ-1:0] mask);
    @(negedge clk_fast);
    req_pulse = mask;
    @(negedge clk_fast);
    req_pulse = '0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
  endtask

  // Release well away from either clock's rising edge.
  task automatic release_reset();
    @(negedge clk_slow);
    #20 rst_n = 1'b1;
    @(negedge clk_fast);
  endtask

  function automatic int drop_total();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += drop_cnt[i];
    return s;
  endfunction

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < IDLE_BUDGET; c++) begin
      @(negedge clk_fast);
      if (busy === 1'b0 && exp_slow_q.size() == 0 && exp_done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b outstanding_slow=%0d outstanding_done=%0d, required idle with none outstanding",
               name, busy, exp_slow_q.size(), exp_done_q.size());
      exp_slow_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (3) @(negedge clk_fast);
    checks++;
    if ({req_drop, busy, done_pulse, done_id, slow_pulse, slow_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: drop=%b busy=%b done=%b done_id=%0d slow=%b slow_id=%0d, required all 0",
               req_drop, busy, done_pulse, done_id, slow_pulse, slow_id);
    end
    release_reset();
  endtask

  task automatic test_single();
    int d0 = drop_total();
    expect_id(2'd2);
    @(negedge clk_fast);
    req_pulse = 4'b0100;
    @(negedge clk_fast);
    req_pulse = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise: got %b, required 1", busy);
    end
    wait_idle("single");
    checks++;
    if (slow_id !== 2'd2) begin
      errors++;
      $display("FAIL single_slow_id_hold: got %0d, required 2", slow_id);
    end
    checks++;
    if (drop_total() != d0) begin
      errors++;
      $display("FAIL single_drop: got %0d drops, required 0", drop_total() - d0);
    end
  endtask

  task automatic test_simultaneous();
    int d0;
    assert_reset();
    release_reset();
    d0 = drop_total();
    expect_id(2'd0);
    expect_id(2'd1);
    expect_id(2'd3);
    pulse(4'b1011);
    wait_idle("simultaneous");
    checks++;
    if (drop_total() != d0) begin
      errors++;
      $display("FAIL simultaneous_drop: got %0d drops, required 0", drop_total() - d0);
    end
  endtask

  // Pointer is 0 on entry; each served requester re-pulses once its transfer
  // completes, so the wrap-around search must alternate 0,1,0,1,...
  task automatic test_round_robin();
    int  d0 = drop_total();
    id_t nxt;
    bit  seen;
    expect_id(2'd0);
    expect_id(2'd1);
    pulse(4'b0011);
    for (int r = 0; r < 4; r++) begin
      seen = 1'b0;
      for (int c = 0; c < IDLE_BUDGET; c++) begin
        @(negedge clk_fast);
        if (done_pulse === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rr_done_timeout: round %0d got no done_pulse, required one", r);
        break;
      end
      nxt = id_t'(r % 2);
      expect_id(nxt);
      pulse(4'b0001 << nxt);
    end
    wait_idle("round_robin");
    checks++;
    if (drop_total() != d0) begin
      errors++;
      $display("FAIL rr_drop: got %0d drops, required 0", drop_total() - d0);
    end
  endtask

  // Pointer is 2 on entry. Requester 0 goes in flight; requester 3 pulses
  // twice while waiting, so the second event is coalesced and reported.
  task automatic test_coalesce();
    int d3 = drop_cnt[3];
    int d0 = drop_total();
    expect_id(2'd0);
    expect_id(2'd3);
    pulse(4'b0001);
    repeat (3) @(negedge clk_fast);
    pulse(4'b1000);
    pulse(4'b1000);
    wait_idle("coalesce");
    checks++;
    if (drop_cnt[3] - d3 != 1) begin
      errors++;
      $display("FAIL coalesce_drop3: got %0d drops, required 1", drop_cnt[3] - d3);
    end
    checks++;
    if (drop_total() - d0 != 1) begin
      errors++;
      $display("FAIL coalesce_drop_total: got %0d drops, required 1", drop_total() - d0);
    end
  endtask

  // Requester 1 pulses on two consecutive cycles from IDLE: the second
  // coincides with its own grant, so it re-arms instead of being dropped.
  task automatic test_set_wins();
    int d0 = drop_total();
    expect_id(2'd1);
    expect_id(2'd1);
    @(negedge clk_fast);
    req_pulse = 4'b0010;
    @(negedge clk_fast);
    req_pulse = 4'b0010;
    @(negedge clk_fast);
    req_pulse = '0;
    wait_idle("set_wins");
    checks++;
    if (drop_total() != d0) begin
      errors++;
      $display("FAIL set_wins_drop: got %0d drops, required 0", drop_total() - d0);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    pulse(4'b0100);
    repeat (3) @(negedge clk_fast);
    assert_reset();
    repeat (5) @(negedge clk_fast);
    checks++;
    if ({req_drop, busy, done_pulse, done_id, slow_pulse, slow_id} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: drop=%b busy=%b done=%b done_id=%0d slow=%b slow_id=%0d, required all 0",
               req_drop, busy, done_pulse, done_id, slow_pulse, slow_id);
    end
    s0 = slow_events;
    release_reset();
    #1500;
    checks++;
    if (slow_events != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stray: got %0d slow events busy=%b, required 0 events busy=0",
               slow_events - s0, busy);
    end
    expect_id(2'd3);
    pulse(4'b1000);
    wait_idle("reset_mid_new");
    checks++;
    if (slow_id !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_slow_id: got %0d, required 3", slow_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_coalesce();
    test_set_wins();
    test_reset_mid();
    repeat (50) @(negedge clk_fast);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
